// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson / ring shift-register sequencer with parallel load,
// illegal-state self-correction, phase decode and wrap/fault pulses.
module johnson_counter_gen #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             legal,
  output logic             wrap,
  output logic             fault
);

  localparam int NS = 2*WIDTH;

  // Johnson phase p: p ones from the MSB (p <= WIDTH), otherwise
  // (p - WIDTH) zeros from the MSB followed by ones.
  function automatic logic [WIDTH-1:0] johnson_pat(input int p);
    logic [WIDTH-1:0] pat;
    for (int b = 0; b < WIDTH; b++) begin
      if (p <= WIDTH) pat[b] = (b >= WIDTH - p);
      else            pat[b] = (b < NS - p);
    end
    return pat;
  endfunction

  function automatic logic [WIDTH-1:0] ring_pat(input int p);
    logic [WIDTH-1:0] pat;
    pat = '0;
    pat[WIDTH-1-p] = 1'b1;
    return pat;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             fault_q, fault_d;

  logic [NS-1:0]    j_hit;
  logic [WIDTH-1:0] r_hit;
  logic [PW-1:0]    phase_c;
  logic             legal_c;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] last_pat;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_jhit
      assign j_hit[gi] = (q_q == johnson_pat(gi));
    end
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rhit
      assign r_hit[gi] = (q_q == ring_pat(gi));
    end
  endgenerate

  // At most one hit is ever set, so OR-ing the matching indices is an encoder.
  always_comb begin
    phase_c = '0;
    legal_c = 1'b0;
    if (mode) begin
      for (int p = 0; p < WIDTH; p++) begin
        if (r_hit[p]) phase_c = phase_c | PW'(p);
      end
      legal_c = |r_hit;
    end else begin
      for (int p = 0; p < NS; p++) begin
        if (j_hit[p]) phase_c = phase_c | PW'(p);
      end
      legal_c = |j_hit;
    end
  end

  // The last phase is 0..01 in both modes.
  assign rs_val   = mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  assign last_pat = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    step_val = q_q;
    case ({mode, dir})
      2'b00: step_val = {~q_q[0], q_q[WIDTH-1:1]};
      2'b01: step_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      2'b10: step_val = {q_q[0], q_q[WIDTH-1:1]};
      2'b11: step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default: step_val = q_q;
    endcase
  end

  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en && legal_c) begin
      q_d    = step_val;
      wrap_d = dir ? (step_val == last_pat) : (step_val == rs_val);
    end else if (en) begin
      q_d     = rs_val;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= rs_val;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign q     = q_q;
  assign phase = phase_c;
  assign legal = legal_c;
  assign wrap  = wrap_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Scoreboard bench for johnson_counter_gen (WIDTH=4): stimulus pushes expected
// observations, a negedge monitor pops and compares them.
module tb_johnson_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, dir, mode, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] phase;
  logic       legal, wrap, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] q;
    logic [2:0] ph;
    logic       lg;
    logic       wr;
    logic       ft;
    string      name;
  } exp_t;

  exp_t sb[$];

  johnson_counter_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q), .phase(phase), .legal(legal), .wrap(wrap), .fault(fault)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per expected observation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (q !== e.q || phase !== e.ph || legal !== e.lg || wrap !== e.wr || fault !== e.ft) begin
        errors++;
        $display("FAIL %s: got q=%b phase=%0d legal=%b wrap=%b fault=%b, want q=%b phase=%0d legal=%b wrap=%b fault=%b",
                 e.name, q, phase, legal, wrap, fault, e.q, e.ph, e.lg, e.wr, e.ft);
      end else begin
        $display("ok   %s: q=%b phase=%0d legal=%b wrap=%b fault=%b",
                 e.name, q, phase, legal, wrap, fault);
      end
    end
  end

  task automatic set_in(input logic r, input logic e, input logic d,
                        input logic m, input logic l, input logic [3:0] lv);
    rst = r; en = e; dir = d; mode = m; load = l; load_val = lv;
  endtask

  task automatic push(input logic [3:0] eq, input int ph, input logic lg,
                      input logic wr, input logic ft, input string nm);
    exp_t e;
    e.q = eq; e.ph = 3'(ph); e.lg = lg; e.wr = wr; e.ft = ft; e.name = nm;
    sb.push_back(e);
  endtask

  // Clock one edge, then expect the given observation at the following negedge.
  task automatic tick(input logic [3:0] eq, input int ph, input logic lg,
                      input logic wr, input logic ft, input string nm);
    @(posedge clk);
    #1;
    push(eq, ph, lg, wr, ft, nm);
    @(negedge clk);
    #1;
  endtask

  // Expect a combinational observation without an intervening edge.
  task automatic peek(input logic [3:0] eq, input int ph, input logic lg,
                      input logic wr, input logic ft, input string nm);
    push(eq, ph, lg, wr, ft, nm);
    @(negedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 4'b0000);
    tick(4'b0000, 0, 1, 0, 0, "reset_johnson");

    // Johnson forward through a full wrap
    set_in(0, 1, 0, 0, 0, 4'b0000);
    tick(4'b1000, 1, 1, 0, 0, "jfwd1");
    tick(4'b1100, 2, 1, 0, 0, "jfwd2");
    tick(4'b1110, 3, 1, 0, 0, "jfwd3");
    tick(4'b1111, 4, 1, 0, 0, "jfwd4");
    tick(4'b0111, 5, 1, 0, 0, "jfwd5");
    tick(4'b0011, 6, 1, 0, 0, "jfwd6");
    tick(4'b0001, 7, 1, 0, 0, "jfwd7");
    tick(4'b0000, 0, 1, 1, 0, "jfwd8_wrap");
    tick(4'b1000, 1, 1, 0, 0, "jfwd9");
    tick(4'b1100, 2, 1, 0, 0, "jfwd10");
    tick(4'b1110, 3, 1, 0, 0, "jfwd11");

    // Reverse, then turn around
    dir = 1;
    tick(4'b1100, 2, 1, 0, 0, "jrev1");
    tick(4'b1000, 1, 1, 0, 0, "jrev2");
    tick(4'b0000, 0, 1, 0, 0, "jrev3");
    tick(4'b0001, 7, 1, 1, 0, "jrev4_wrap");
    dir = 0;
    tick(4'b0000, 0, 1, 1, 0, "jturn_fwd_wrap");

    // Ring mode
    set_in(1, 0, 0, 1, 0, 4'b0000);
    tick(4'b1000, 0, 1, 0, 0, "reset_ring");
    set_in(0, 1, 0, 1, 0, 4'b0000);
    tick(4'b0100, 1, 1, 0, 0, "rfwd1");
    tick(4'b0010, 2, 1, 0, 0, "rfwd2");
    tick(4'b0001, 3, 1, 0, 0, "rfwd3");
    tick(4'b1000, 0, 1, 1, 0, "rfwd4_wrap");
    dir = 1;
    tick(4'b0001, 3, 1, 1, 0, "rrev_wrap");

    // Illegal load, hold, self-correction
    set_in(0, 0, 0, 0, 1, 4'b1010);
    tick(4'b1010, 0, 0, 0, 0, "load_illegal");
    load = 0;
    tick(4'b1010, 0, 0, 0, 0, "illegal_hold");
    en = 1;
    tick(4'b0000, 0, 1, 0, 1, "correct_fault");
    tick(4'b1000, 1, 1, 0, 0, "after_fault");

    // Priority: rst over load over en
    set_in(1, 1, 0, 0, 1, 4'b1111);
    tick(4'b0000, 0, 1, 0, 0, "prio_rst");
    set_in(0, 1, 0, 0, 1, 4'b0111);
    tick(4'b0111, 5, 1, 0, 0, "prio_load");

    // Hold for 5 cycles
    set_in(0, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) tick(4'b0111, 5, 1, 0, 0, "hold");

    // Mode switch with an incompatible state
    set_in(0, 0, 0, 0, 1, 4'b1100);
    tick(4'b1100, 2, 1, 0, 0, "load_1100");
    load = 0;
    mode = 1;
    peek(4'b1100, 0, 0, 0, 0, "mode_switch_illegal");
    en = 1;
    tick(4'b1000, 0, 1, 0, 1, "mode_switch_fault");
    tick(4'b0100, 1, 1, 0, 0, "mode_switch_step");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d observations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
